pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline. It generates the en/flush pair for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It also gates the data-cache request so that an access completes exactly once while the pipeline is frozen. It resolves instruction-fetch stalls, data-access stalls, load-use hazards, taken branches/JR, ID-stage jumps and halt.

Parameters:
CNT_W, 32, width of the optional performance counters

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  MEM-stage instruction is a load
mem_dWEN  in  1  MEM-stage instruction is a store
mem_halt  in  1  MEM-stage instruction is HALT
mem_brtaken  in  1  taken branch/JR resolved in MEM
id_jump  in  1  J/JAL decoded in ID
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_usesrt  in  1  ID instruction reads rt
ex_dREN  in  1  EX-stage instruction is a load
ex_rt  in  5  EX-stage load destination
dmemREN  out  1  gated load request to the data cache
dmemWEN  out  1  gated store request to the data cache
pc_en  out  1  PC update enable
ifid_en, ifid_flush  out  1 each  IF/ID register controls
idex_en, idex_flush  out  1 each  ID/EX register controls
exmem_en, exmem_flush  out  1 each  EX/MEM register controls
memwb_en, memwb_flush  out  1 each  MEM/WB register controls
halt  out  1  processor halted (registered)
stall_cnt  out  CNT_W  frozen-cycle count (optional feature)
flush_cnt  out  CNT_W  branch/jump flush count (optional feature)

Behaviour:
- Clock is CLK. RST is synchronous and active-high. All state changes occur on the rising edge of CLK.
- Reset values: FSM=RUN, ddone=0, halt=0, counters=0.
- Combinational outputs while RST is high: all en=1, all flush=1. This zeroes every pipeline register.
- Pipeline registers load zeros when en=1 and flush=1. A flush output is meaningful only when its en is 1.
- FSM has three states: RUN, DDONE, HALTED.
  - RUN: ddone=0.
  - DDONE: data access already finished; the controller is waiting for ihit.
  - HALTED: absorbing until RST.
- Derived signals:
  - mreq = mem_dREN | mem_dWEN.
  - dpend = mreq & (state != DDONE) & ~dhit.
  - adv = ihit & ~dpend & (state != HALTED).
- FSM transitions:
  - RUN -> DDONE when mreq & dhit & ~ihit.
  - DDONE -> RUN when ihit.
  - RUN or DDONE -> HALTED when adv & mem_halt. The halt register is set to 1 on the same edge.
- Cache request gating:
  - dmemREN = mem_dREN & (state == RUN).
  - dmemWEN = mem_dWEN & (state == RUN).
  - Requests are deasserted in DDONE and HALTED. No access is ever repeated.
- Priority of actions, evaluated every cycle, highest first:
  1. state == HALTED: all en=0, pc_en=0, all flush=0.
  2. ~adv (freeze): all en=0, pc_en=0.
  3. mem_halt: pc_en=0. IF/ID, ID/EX and EX/MEM get en=1, flush=1. MEM/WB gets en=1, flush=0.
  4. mem_brtaken: pc_en=1 (PC loads the target). IF/ID, ID/EX and EX/MEM get en=1, flush=1. MEM/WB advances normally.
  5. Load-use hazard, lu = ex_dREN & (ex_rt != 0) & ((ex_rt == id_rs) | (id_usesrt & (ex_rt == id_rt))):
     - pc_en=0 and ifid_en=0 (hold).
     - ID/EX gets en=1, flush=1 (bubble).
     - EX/MEM and MEM/WB advance.
  6. id_jump: pc_en=1. IF/ID gets en=1, flush=1. All other registers advance.
  7. Otherwise: all en=1, flush=0, pc_en=1.
- Simultaneous events resolve strictly by the order above. Example: mem_brtaken with lu asserted gives branch behaviour; the bubble is not inserted.
- Register $0 never causes a load-use stall.
- Latency: load-use inserts exactly 1 bubble. A branch costs 3 flushed slots. A jump costs 1 flushed slot.
- If RST is asserted mid-freeze or in HALTED, the next cycle is RUN with ddone cleared. No pending cache request survives reset.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - stall_cnt increments on every cycle where ~adv and state != HALTED.
  - flush_cnt increments once per cycle where priority 4 or 6 is taken.
  - Both counters saturate at all-ones and clear on RST.
- When undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset: hold RST=1 for 2 cycles, then release with ihit=1 and no hazards -> cycle after release shows all en=1, flush=0, pc_en=1, halt=0; stall_cnt=0.
- Load-use: ex_dREN=1, ex_rt=5, id_rs=5, ihit=1 -> for 1 cycle pc_en=0, ifid_en=0, idex_en=1/idex_flush=1. Repeat with ex_rt=0 -> no stall.
- Data stall, then ifetch stall:
  - Cycle 0: mem_dREN=1, dhit=0, ihit=1 -> all en=0, dmemREN=1.
  - Cycle 1: dhit=1, ihit=0 -> state DDONE, all en=0.
  - Cycle 2: dhit=0, ihit=0 -> dmemREN=0, all en=0.
  - Cycle 3: ihit=1 -> all en=1, state RUN.
- Branch plus load-use: mem_brtaken=1 and lu=1, ihit=1 -> pc_en=1; ifid, idex, exmem get en=1/flush=1; memwb_en=1/flush=0. Next cycle with no hazards is normal; flush_cnt=1 with HAZARD_PERF_EN.
- Jump: id_jump=1, ihit=1 -> ifid_en=1/ifid_flush=1; all other flushes 0.
- Halt: mem_halt=1, ihit=1 -> memwb_en=1, pc_en=0. Next cycle halt=1 and all en=0, held for 10 cycles regardless of inputs. RST=1 then returns to RUN with halt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central pipeline sequencer for the five-stage core.
// Drives en/flush for IF/ID, ID/EX, EX/MEM, MEM/WB, the PC enable and
// gated data-cache requests. Resolves fetch/data stalls, load-use hazards,
// taken branches, ID jumps and halt.
// Build option: define HAZARD_PERF_EN to add saturating stall/flush counters;
// without it stall_cnt and flush_cnt are tied to zero.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal operation, no data access completed early
// DDONE  | data access already finished, waiting for ihit to advance
// HALTED | HALT retired, everything frozen until RST
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             mem_brtaken,
  input  logic             id_jump,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesrt,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_rt,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  logic mreq;
  logic dpend;
  logic adv;
  logic lu;
  logic ddone;

  // Hazard detection and pipeline-advance qualification
  always_comb begin
    mreq  = mem_dREN | mem_dWEN;
    ddone = (state == DDONE);
    dpend = mreq & ~ddone & ~dhit;
    adv   = ihit & ~dpend & (state != HALTED);
    lu    = ex_dREN & (ex_rt != 5'd0) &
            ((ex_rt == id_rs) | (id_usesrt & (ex_rt == id_rt)));
  end

  // Sequencer state and registered halt flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (adv && mem_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (mreq && dhit && !ihit) begin
            state <= DDONE;
          end
        end
        DDONE: begin
          if (adv && mem_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (ihit) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

  // Prioritised pipeline-register control; reset zeroes every stage
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == HALTED || !adv) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_halt) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_brtaken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Cache requests only issue from RUN so a finished access is never replayed
  always_comb begin
    dmemREN = mem_dREN & (state == RUN) & ~RST;
    dmemWEN = mem_dWEN & (state == RUN) & ~RST;
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // Event qualifiers for the performance counters
  always_comb begin
    stall_inc = ~adv & (state != HALTED);
    flush_inc = adv & ~mem_halt & (mem_brtaken | (~lu & id_jump));
  end

  // Saturating performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
